// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and the register file.
// PPP mode encodings must stay in step with the register file's decoder.
package rf_wb_arbiter_pkg;

    localparam int PPP_WIDTH      = 3;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [PPP_WIDTH-1:0] {
        PPP_A = 3'b000,
        PPP_U = 3'b001,
        PPP_D = 3'b010,
        PPP_E = 3'b011,
        PPP_O = 3'b100
    } ppp_mode_e;

    // Encodings above PPP_O have no meaning to the register file.
    function automatic logic ppp_is_legal(input logic [PPP_WIDTH-1:0] ppp);
        return ppp <= PPP_O;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: ALU source, load-return source and the register-file write port.
// The slave modport is the arbiter's view; master is everything around it.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  alu_wb_valid;
    logic                  alu_wb_ready;
    logic [ADDR_WIDTH-1:0] alu_wr_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic [PPP_WIDTH-1:0]  alu_ppp;

    logic                  mem_wb_valid;
    logic                  mem_wb_ready;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [PPP_WIDTH-1:0]  mem_ppp;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_wr_addr;
    logic [DATA_WIDTH-1:0] rf_data_in;
    logic [PPP_WIDTH-1:0]  rf_ppp_sel;
    logic                  pipe_stall;
    logic                  err_ppp;

    modport slave (
        input  alu_wb_valid, alu_wr_addr, alu_data, alu_ppp,
        input  mem_wb_valid, mem_wr_addr, mem_data, mem_ppp,
        output alu_wb_ready, mem_wb_ready,
        output rf_wen, rf_wr_addr, rf_data_in, rf_ppp_sel, pipe_stall, err_ppp
    );

    modport master (
        output alu_wb_valid, alu_wr_addr, alu_data, alu_ppp,
        output mem_wb_valid, mem_wr_addr, mem_data, mem_ppp,
        input  alu_wb_ready, mem_wb_ready,
        input  rf_wen, rf_wr_addr, rf_data_in, rf_ppp_sel, pipe_stall, err_ppp
    );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Load-return buffer: synchronous FIFO, no bypass, push ignored while full.
// Pointers carry one wrap bit so full and empty are distinguishable.
module rf_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Sole owner of the register-file write port: ALU writebacks first, buffered
// load returns otherwise, with a one-cycle ALU stall when loads starve.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int ENTRY_W = ADDR_WIDTH + PPP_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [PPP_WIDTH-1:0]  head_ppp;
    logic [DATA_WIDTH-1:0] head_data;

    logic                  alu_grant, grant, unserved;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [PPP_WIDTH-1:0]  sel_ppp;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  stall_q, stall_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic [PPP_WIDTH-1:0]  rf_ppp_q, rf_ppp_d;
    logic                  err_q, err_d;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({bus.mem_wr_addr, bus.mem_ppp, bus.mem_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (head)
    );

    assign {head_addr, head_ppp, head_data} = head;

    // A stall cycle belongs to the FIFO; otherwise the ALU always wins.
    assign alu_grant = bus.alu_wb_valid && !stall_q;
    assign fifo_pop  = !fifo_empty && (stall_q || !bus.alu_wb_valid);
    assign fifo_push = bus.mem_wb_valid && !fifo_full;
    assign grant     = alu_grant || fifo_pop;
    assign unserved  = !fifo_empty && !fifo_pop;

    assign bus.alu_wb_ready = alu_grant;
    assign bus.mem_wb_ready = !fifo_full;

    always_comb begin
        sel_addr = alu_grant ? bus.alu_wr_addr : head_addr;
        sel_data = alu_grant ? bus.alu_data    : head_data;
        sel_ppp  = alu_grant ? bus.alu_ppp     : head_ppp;

        cnt_d   = cnt_q;
        stall_d = 1'b0;
        if (!unserved) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST && !stall_q) begin
            stall_d = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Illegal PPP and r0 writes still consume the grant but never write.
        rf_wen_d  = grant && (sel_addr != '0) && ppp_is_legal(sel_ppp);
        rf_addr_d = grant ? sel_addr : rf_addr_q;
        rf_data_d = grant ? sel_data : rf_data_q;
        rf_ppp_d  = grant ? sel_ppp  : rf_ppp_q;
        err_d     = err_q || (grant && !ppp_is_legal(sel_ppp));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            rf_wen_q  <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            rf_ppp_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            rf_wen_q  <= rf_wen_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            rf_ppp_q  <= rf_ppp_d;
            err_q     <= err_d;
        end
    end

    assign bus.rf_wen     = rf_wen_q;
    assign bus.rf_wr_addr = rf_addr_q;
    assign bus.rf_data_in = rf_data_q;
    assign bus.rf_ppp_sel = rf_ppp_q;
    assign bus.pipe_stall = stall_q;
    assign bus.err_ppp    = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes are queued as stimulus is
// driven and popped whenever the DUT pulses rf_wen.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
        logic [2:0]  ppp;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_t         sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] rf_model [32];

    always @(posedge clk) begin
        if (bus.rf_wen) rf_model[bus.rf_wr_addr] <= bus.rf_data_in;
    end

    function automatic wr_t mk(input logic [4:0] a, input logic [63:0] d, input logic [2:0] p);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.ppp  = p;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, score any write.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (bus.rf_wen) begin
            check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                w = sb_q.pop_front();
                check("wr_addr", 64'(bus.rf_wr_addr), 64'(w.addr));
                check("wr_data", bus.rf_data_in, w.data);
                check("wr_ppp", 64'(bus.rf_ppp_sel), 64'(w.ppp));
            end
        end
    endtask

    initial begin
        int k;
        reset            = 1'b1;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wr_addr  = '0;
        bus.alu_data     = '0;
        bus.alu_ppp      = '0;
        bus.mem_wb_valid = 1'b0;
        bus.mem_wr_addr  = '0;
        bus.mem_data     = '0;
        bus.mem_ppp      = '0;

        // Reset then idle
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("idle_wen", 64'(bus.rf_wen), 64'd0);
        check("idle_stall", 64'(bus.pipe_stall), 64'd0);
        check("idle_mem_ready", 64'(bus.mem_wb_ready), 64'd1);
        check("idle_err", 64'(bus.err_ppp), 64'd0);
        check("idle_addr", 64'(bus.rf_wr_addr), 64'd0);
        check("idle_data", bus.rf_data_in, 64'd0);

        // ALU only
        bus.alu_wb_valid = 1'b1;
        bus.alu_wr_addr  = 5'd5;
        bus.alu_data     = 64'h1122334455667788;
        bus.alu_ppp      = PPP_A;
        #1;
        check("alu_ready", 64'(bus.alu_wb_ready), 64'd1);
        sb_q.push_back(mk(5'd5, 64'h1122334455667788, PPP_A));
        tick();
        bus.alu_wb_valid = 1'b0;
        check("alu_wen", 64'(bus.rf_wen), 64'd1);
        tick(); tick();
        check("rf_r5", rf_model[5], 64'h1122334455667788);

        // Simultaneous ALU and load, then fill FIFO
        bus.alu_wb_valid = 1'b1;
        bus.alu_wr_addr  = 5'd3;
        bus.alu_data     = 64'hAAAA_0000_0000_0003;
        bus.alu_ppp      = PPP_A;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wr_addr  = 5'd7;
        bus.mem_data     = 64'hBBBB_0000_0000_0007;
        bus.mem_ppp      = PPP_U;
        #1;
        check("both_alu_ready", 64'(bus.alu_wb_ready), 64'd1);
        check("both_mem_ready", 64'(bus.mem_wb_ready), 64'd1);
        sb_q.push_back(mk(5'd3, 64'hAAAA_0000_0000_0003, PPP_A));
        tick();
        bus.alu_wr_addr  = 5'd11;
        bus.alu_data     = 64'hAAAA_0000_0000_000B;
        bus.alu_ppp      = PPP_D;
        bus.mem_wr_addr  = 5'd8;
        bus.mem_data     = 64'hBBBB_0000_0000_0008;
        bus.mem_ppp      = PPP_E;
        #1;
        check("second_alu_ready", 64'(bus.alu_wb_ready), 64'd1);
        check("second_mem_ready", 64'(bus.mem_wb_ready), 64'd1);
        sb_q.push_back(mk(5'd11, 64'hAAAA_0000_0000_000B, PPP_D));
        tick();
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;
        #1;
        check("fifo_full_ready", 64'(bus.mem_wb_ready), 64'd0);
        sb_q.push_back(mk(5'd7, 64'hBBBB_0000_0000_0007, PPP_U));
        tick();
        check("after_pop_ready", 64'(bus.mem_wb_ready), 64'd1);
        sb_q.push_back(mk(5'd8, 64'hBBBB_0000_0000_0008, PPP_E));
        tick(); tick();

        // Starvation: continuous ALU, one buffered load
        k = 0;
        for (int i = 0; i < 7; i++) begin
            bus.alu_wb_valid = 1'b1;
            bus.alu_wr_addr  = 5'd12;
            bus.alu_data     = 64'hC000 + 64'(k);
            bus.alu_ppp      = PPP_A;
            bus.mem_wb_valid = (i == 0);
            bus.mem_wr_addr  = 5'd9;
            bus.mem_data     = 64'hDDDD_0000_0000_0009;
            bus.mem_ppp      = PPP_O;
            #1;
            check("starve_stall", 64'(bus.pipe_stall), 64'(i == 5));
            check("starve_alu_ready", 64'(bus.alu_wb_ready), 64'(i != 5));
            if (i == 5) begin
                sb_q.push_back(mk(5'd9, 64'hDDDD_0000_0000_0009, PPP_O));
            end else begin
                sb_q.push_back(mk(5'd12, 64'hC000 + 64'(k), PPP_A));
                k++;
            end
            tick();
        end
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;
        tick(); tick();
        check("starve_done_stall", 64'(bus.pipe_stall), 64'd0);

        // r0 write and illegal PPP: consumed but never written
        bus.alu_wb_valid = 1'b1;
        bus.alu_wr_addr  = 5'd0;
        bus.alu_data     = 64'h0D0D;
        bus.alu_ppp      = PPP_A;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wr_addr  = 5'd4;
        bus.mem_data     = 64'h0E0E;
        bus.mem_ppp      = 3'b110;
        tick();
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;
        check("r0_wen", 64'(bus.rf_wen), 64'd0);
        check("r0_data_latched", bus.rf_data_in, 64'h0D0D);
        check("r0_err", 64'(bus.err_ppp), 64'd0);
        tick();
        check("badppp_wen", 64'(bus.rf_wen), 64'd0);
        check("badppp_addr", 64'(bus.rf_wr_addr), 64'd4);
        check("badppp_sel", 64'(bus.rf_ppp_sel), 64'd6);
        check("badppp_err", 64'(bus.err_ppp), 64'd1);
        tick(); tick(); tick();
        check("err_sticky", 64'(bus.err_ppp), 64'd1);

        // Fill FIFO then reset: buffered loads must be discarded
        bus.alu_wb_valid = 1'b1;
        bus.alu_wr_addr  = 5'd13;
        bus.alu_data     = 64'hE0;
        bus.alu_ppp      = PPP_A;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wr_addr  = 5'd14;
        bus.mem_data     = 64'hF0;
        bus.mem_ppp      = PPP_A;
        #1;
        sb_q.push_back(mk(5'd13, 64'hE0, PPP_A));
        tick();
        bus.alu_data    = 64'hE1;
        bus.mem_wr_addr = 5'd15;
        bus.mem_data    = 64'hF1;
        #1;
        sb_q.push_back(mk(5'd13, 64'hE1, PPP_A));
        tick();
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("prereset_full", 64'(bus.mem_wb_ready), 64'd0);
        tick();
        reset = 1'b0;
        check("rst_mem_ready", 64'(bus.mem_wb_ready), 64'd1);
        check("rst_wen", 64'(bus.rf_wen), 64'd0);
        check("rst_stall", 64'(bus.pipe_stall), 64'd0);
        check("rst_err", 64'(bus.err_ppp), 64'd0);
        check("rst_addr", 64'(bus.rf_wr_addr), 64'd0);
        tick(); tick(); tick(); tick();
        check("post_rst_mem_ready", 64'(bus.mem_wb_ready), 64'd1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Single-owner controller for the register file's one write port (wen / wr_addr / data_in / PPP_sel).
- Shares the port between two writeback sources:
  - ALU pipeline: in-order, high priority.
  - Memory/NIC load-return path: buffered in a small FIFO, with a starvation guard.
- Sits between the execute/memory stages and the register file. Drives a registered write port, so it lands one cycle after acceptance.

Parameters:
- DATA_WIDTH, 64, write data width
- ADDR_WIDTH, 5, register address width
- FIFO_DEPTH, 2, load-return buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may go unserved before a stall is forced (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_ready  out  1  ALU request accepted this cycle
- alu_wr_addr  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ppp  in  3  ALU participate select
- mem_wb_valid  in  1  load-return request
- mem_wb_ready  out  1  FIFO can accept (= not full)
- mem_wr_addr  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- mem_ppp  in  3  load participate select
- rf_wen  out  1  to register file wen
- rf_wr_addr  out  ADDR_WIDTH  to register file wr_addr
- rf_data_in  out  DATA_WIDTH  to register file data_in
- rf_ppp_sel  out  3  to register file PPP_sel
- pipe_stall  out  1  one-cycle stall request to the ALU pipeline
- err_ppp  out  1  sticky: a granted write carried PPP 101..111

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - FIFO empty; starve counter 0.
  - pipe_stall, rf_wen, err_ppp all 0.
  - rf_wr_addr, rf_data_in, rf_ppp_sel all 0.
  - Reset mid-operation discards FIFO contents and any pending stall.
- FIFO:
  - mem_wb_ready = !full.
  - Push on mem_wb_valid && mem_wb_ready.
  - Push while full is impossible; no push-through-pop when full.
  - Push into an empty FIFO is not poppable until the next cycle (no bypass).
- Grant, evaluated each cycle in priority order:
  1. pipe_stall=1: alu_wb_ready=0 and the ALU must hold its request. Pop the FIFO head if non-empty.
  2. Else if alu_wb_valid: alu_wb_ready=1 and the ALU is granted.
  3. Else if FIFO non-empty: pop the head.
  4. Else: idle.
- Output register:
  - The granted request is registered into rf_* at the clock edge.
  - rf_wen is high for exactly one cycle per grant. Timing: accepted at edge N, rf_wen high during cycle N..N+1, register file updated at edge N+1.
  - rf_wen=0 (grant still consumed, no write) when:
    - wr_addr==0, or
    - PPP is 101..111, which also sets err_ppp (cleared only by reset).
  - When idle: rf_wen=0; addr/data/ppp hold their last value.
- Starvation:
  - cnt increments when the FIFO is non-empty and no pop occurs.
  - cnt clears on any pop or when the FIFO is empty.
  - When cnt==STARVE_LIMIT-1 and the FIFO is still unserved, pipe_stall is registered high for the next cycle only, and cnt clears.
  - pipe_stall never asserts on two consecutive cycles.
- Ordering:
  - Load returns are written in FIFO order.
  - An ALU write and a load write to the same register resolve by grant order; the later grant wins.

Decomposition:
- Shared package holds:
  - PPP mode constants (a=000, u=001, d=010, e=011, o=100), shared with the register file.
  - PPP_WIDTH=3.
  - Default DATA_WIDTH/ADDR_WIDTH.
- One sub-module: rf_wb_fifo, a synchronous FIFO.
  - Parameters: FIFO_DEPTH, width = ADDR_WIDTH+3+DATA_WIDTH.
  - Ports: push/pop/full/empty and head data.
- The arbiter holds the grant logic, starvation counter and output register.

Test Plan:
- Reset, then idle 3 cycles -> rf_wen=0, pipe_stall=0, mem_wb_ready=1, err_ppp=0.
- ALU only: addr 5, data 0x1122334455667788, ppp 000 -> next cycle rf_wen=1, rf_wr_addr=5, rf_ppp_sel=000, same data. A register-file read of r5 two cycles later returns the data.
- Simultaneous ALU (addr 3) and load (addr 7) -> ALU written first; load written the cycle after the ALU drops valid. mem_wb_ready goes 0 after two more pushes with no pops.
- Continuous alu_wb_valid, one load buffered, STARVE_LIMIT=4:
  - pipe_stall=1 exactly once, four cycles after the push; alu_wb_ready=0 that cycle.
  - Load to addr 9 is written next; ALU resumes the following cycle.
- Writes to addr 0 (ALU) and ppp=110 (load, addr 4) -> both consumed, rf_wen stays 0, err_ppp=1 and stays set.
- FIFO full (2 entries), assert reset for one cycle -> FIFO empty, mem_wb_ready=1, no rf_wen pulse from the discarded entries.
